// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time req/ack fetches and
// buffers returned words in a small prefetch FIFO ahead of the decoder.
module instr_fetch #(
  parameter int                  PC_WIDTH   = 8,
  parameter int                  FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [15:0]         NOP_INSTR  = 16'h0000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic                i_pc_load,
  input  logic [PC_WIDTH-1:0] i_pc_value,
  output logic                o_imem_req,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic                i_imem_ack,
  input  logic [15:0]         i_imem_data,
  output logic [15:0]         o_instruction,
  output logic                o_valid,
  input  logic                i_stall,
  output logic [PC_WIDTH-1:0] o_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE = PTR_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [15:0]         buf_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic fill_ok;

  // A PC load overrides both a same-cycle pop and a same-cycle ack.
  assign push = (state_q == S_FETCH) && i_imem_ack && !i_pc_load;
  assign pop  = (count_q != '0) && !i_stall && !i_pc_load;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_pc_load) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    // Room is judged on the post-edge occupancy so the next request can never overflow.
    fill_ok    = i_run && (count_d < DEPTH_C);

    case (state_q)
      S_IDLE: begin
        if (!i_pc_load && fill_ok) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          state_d = fill_ok ? S_FETCH : S_IDLE;
        end else if (i_pc_load) begin
          state_d    = S_DISCARD;
          req_addr_d = pc_q;
        end
      end
      S_DISCARD: begin
        if (i_imem_ack) state_d = fill_ok ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_pc_load) pc_d = i_pc_value;
    else if (push) pc_d = pc_q + PC_ONE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) buf_q[wr_ptr_q] <= i_imem_data;
  end

  // While discarding, the abandoned request keeps its original address until acked.
  assign o_imem_req    = (state_q != S_IDLE);
  assign o_imem_addr   = (state_q == S_DISCARD) ? req_addr_q : pc_q;
  assign o_valid       = (count_q != '0);
  assign o_instruction = o_valid ? buf_q[rd_ptr_q] : NOP_INSTR;
  assign o_pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-configurable memory model plus a stream
// scoreboard that predicts delivered words from the PC/load history.
module tb_instr_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst, i_run, i_pc_load, i_stall;
  logic [7:0]  i_pc_value;
  logic        i_imem_ack;
  logic [15:0] i_imem_data;
  logic        o_imem_req, o_valid;
  logic [7:0]  o_imem_addr, o_pc;
  logic [15:0] o_instruction;

  int errors = 0;
  int checks = 0;
  int lat = 0;
  bit rand_lat = 1'b0;

  instr_fetch dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (i_run),
    .i_pc_load    (i_pc_load),
    .i_pc_value   (i_pc_value),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_data  (i_imem_data),
    .o_instruction(o_instruction),
    .o_valid      (o_valid),
    .i_stall      (i_stall),
    .o_pc         (o_pc)
  );

  initial forever #5 i_clk = ~i_clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'hA500 ^ {8'h00, a};
  endfunction

  // Memory: acks after cur_lat wait cycles; ack seen in the cycle req rises when latency is 0.
  initial begin : memory
    int wcnt;
    int cur_lat;
    wcnt = 0;
    cur_lat = 0;
    i_imem_ack = 1'b0;
    i_imem_data = 16'h0;
    forever begin
      @(negedge i_clk);
      i_imem_data = 16'($urandom);
      if (i_rst === 1'b1 || o_imem_req !== 1'b1) begin
        i_imem_ack = 1'b0;
        wcnt = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end else if (wcnt >= cur_lat) begin
        i_imem_ack = 1'b1;
        i_imem_data = mem_word(o_imem_addr);
        wcnt = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
      end else begin
        i_imem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  // Scoreboard: delivered words must be consecutive memory words from the last loaded PC.
  initial begin : monitor
    logic [7:0]  exp_addr;
    logic        p_ok, p_vld, p_stall, p_load, p_req, p_ack;
    logic [15:0] p_instr;
    logic [7:0]  p_addr;
    exp_addr = 8'h00;
    p_ok = 1'b0;
    p_vld = 1'b0; p_stall = 1'b0; p_load = 1'b0; p_req = 1'b0; p_ack = 1'b0;
    p_instr = 16'h0; p_addr = 8'h0;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rst !== 1'b0) begin
        exp_addr = 8'h00;
        p_ok = 1'b0;
      end else begin
        if (p_ok) begin
          if (p_load) begin
            checks++;
            if (o_valid !== 1'b0) begin
              errors++;
              $display("FAIL flush_valid: o_valid=%b required 0", o_valid);
            end
          end else if (p_vld && p_stall) begin
            checks++;
            if (o_valid !== 1'b1 || o_instruction !== p_instr) begin
              errors++;
              $display("FAIL stall_hold: valid=%b instr=%h required valid=1 instr=%h",
                       o_valid, o_instruction, p_instr);
            end
          end
          if (p_req && !p_ack) begin
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== p_addr) begin
              errors++;
              $display("FAIL req_hold: req=%b addr=%h required req=1 addr=%h",
                       o_imem_req, o_imem_addr, p_addr);
            end
          end
        end
        if (o_valid !== 1'b1) begin
          checks++;
          if (o_valid !== 1'b0 || o_instruction !== 16'h0000) begin
            errors++;
            $display("FAIL nop_when_empty: valid=%b instr=%h required valid=0 instr=0000",
                     o_valid, o_instruction);
          end
        end else if (!i_stall && !i_pc_load) begin
          checks++;
          if (o_instruction !== mem_word(exp_addr)) begin
            errors++;
            $display("FAIL stream_order: instr=%h required %h", o_instruction, mem_word(exp_addr));
          end
          exp_addr = exp_addr + 8'h01;
        end
        if (i_pc_load) exp_addr = i_pc_value;
        p_vld = o_valid; p_stall = i_stall; p_load = i_pc_load;
        p_req = o_imem_req; p_ack = i_imem_ack;
        p_instr = o_instruction; p_addr = o_imem_addr;
        p_ok = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_run = 1'b0; i_pc_load = 1'b0; i_stall = 1'b0; i_pc_value = 8'h00;
    next();
    next();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    next();
    checks += 5;
    if (o_valid !== 1'b0)           begin errors++; $display("FAIL reset_valid: got %b required 0", o_valid); end
    if (o_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h required 0000", o_instruction); end
    if (o_imem_req !== 1'b0)        begin errors++; $display("FAIL reset_req: got %b required 0", o_imem_req); end
    if (o_imem_addr !== 8'h00)      begin errors++; $display("FAIL reset_addr: got %h required 00", o_imem_addr); end
    if (o_pc !== 8'h00)             begin errors++; $display("FAIL reset_pc: got %h required 00", o_pc); end
  endtask

  task automatic test_zero_wait();
    lat = 0; rand_lat = 1'b0;
    do_reset();
    i_run = 1'b1;
    next();
    checks += 3;
    if (o_imem_req !== 1'b1)   begin errors++; $display("FAIL zw_req: got %b required 1", o_imem_req); end
    if (o_imem_addr !== 8'h00) begin errors++; $display("FAIL zw_addr: got %h required 00", o_imem_addr); end
    if (o_valid !== 1'b0)      begin errors++; $display("FAIL zw_valid_c1: got %b required 0", o_valid); end
    for (int k = 0; k < 3; k++) begin
      next();
      checks += 2;
      if (o_valid !== 1'b1 || o_instruction !== mem_word(8'(k))) begin
        errors++;
        $display("FAIL zw_instr%0d: valid=%b instr=%h required %h", k, o_valid, o_instruction, mem_word(8'(k)));
      end
      if (o_pc !== 8'(k + 1)) begin
        errors++;
        $display("FAIL zw_pc%0d: got %h required %h", k, o_pc, 8'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    bit seen;
    lat = 0; rand_lat = 1'b0;
    do_reset();
    i_stall = 1'b1; i_run = 1'b1;
    repeat (5) next();
    checks += 2;
    if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_drop: got %b required 0", o_imem_req); end
    if (o_valid !== 1'b1 || o_instruction !== 16'hA500) begin
      errors++; $display("FAIL stall_head: valid=%b instr=%h required A500", o_valid, o_instruction);
    end
    i_stall = 1'b0; i_run = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_valid === 1'b1) begin
        checks++;
        if (o_instruction !== mem_word(8'(n))) begin
          errors++; $display("FAIL stall_drain%0d: got %h required %h", n, o_instruction, mem_word(8'(n)));
        end
        n++;
      end
      next();
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL stall_count: got %0d words required 2", n); end
    i_run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      next();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || o_instruction !== 16'hA502) begin
      errors++; $display("FAIL stall_resume: seen=%b instr=%h required A502", seen, o_instruction);
    end
  endtask

  task automatic test_latency();
    int cnt;
    lat = 3; rand_lat = 1'b0;
    do_reset();
    i_run = 1'b1;
    repeat (8) next();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_valid === 1'b1) cnt++;
      next();
    end
    checks++;
    if (cnt != 10) begin errors++; $display("FAIL lat_throughput: got %0d valid cycles required 10", cnt); end
  endtask

  task automatic test_pc_load();
    bit found;
    bit seen;
    lat = 3; rand_lat = 1'b0;
    do_reset();
    i_run = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      next();
      if (o_imem_req === 1'b1 && o_imem_addr === 8'h05) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL load_reach5: request to 05 got req=%b addr=%h", o_imem_req, o_imem_addr);
      return;
    end
    i_pc_load = 1'b1; i_pc_value = 8'h40;
    next();
    i_pc_load = 1'b0;
    checks++;
    if (o_pc !== 8'h40) begin errors++; $display("FAIL load_pc: got %h required 40", o_pc); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 8'h05 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_discard%0d: req=%b addr=%h valid=%b required 1/05/0", c, o_imem_req, o_imem_addr, o_valid);
      end
      next();
    end
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 8'h40 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_newreq: req=%b addr=%h valid=%b required 1/40/0", o_imem_req, o_imem_addr, o_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      next();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || o_instruction !== 16'hA540) begin
      errors++; $display("FAIL load_first: seen=%b instr=%h required A540", seen, o_instruction);
    end
  endtask

  task automatic test_wrap_and_coincident_load();
    bit seen;
    lat = 0; rand_lat = 1'b0;
    do_reset();
    i_pc_load = 1'b1; i_pc_value = 8'hFF;
    next();
    i_pc_load = 1'b0; i_run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      next();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    checks += 2;
    if (!seen || o_instruction !== 16'hA5FF) begin
      errors++; $display("FAIL wrap_ff: seen=%b instr=%h required A5FF", seen, o_instruction);
    end
    if (o_pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h required 00", o_pc); end
    next();
    checks++;
    if (o_valid !== 1'b1 || o_instruction !== 16'hA500) begin
      errors++; $display("FAIL wrap_00: valid=%b instr=%h required A500", o_valid, o_instruction);
    end
    i_pc_load = 1'b1; i_pc_value = 8'h80;
    next();
    i_pc_load = 1'b0;
    checks += 3;
    if (o_pc !== 8'h80)   begin errors++; $display("FAIL coload_pc: got %h required 80", o_pc); end
    if (o_valid !== 1'b0) begin errors++; $display("FAIL coload_valid: got %b required 0", o_valid); end
    if (o_imem_req !== 1'b1 || o_imem_addr !== 8'h80) begin
      errors++; $display("FAIL coload_req: req=%b addr=%h required 1/80", o_imem_req, o_imem_addr);
    end
    next();
    checks++;
    if (o_valid !== 1'b1 || o_instruction !== 16'hA580) begin
      errors++; $display("FAIL coload_first: valid=%b instr=%h required A580", o_valid, o_instruction);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    lat = 3; rand_lat = 1'b0;
    do_reset();
    i_stall = 1'b1; i_run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      next();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    next();
    next();
    checks++;
    if (o_imem_req !== 1'b1 || o_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: req=%b valid=%b required 1/1", o_imem_req, o_valid);
    end
    i_rst = 1'b1;
    #1;
    checks += 5;
    if (o_valid !== 1'b0)           begin errors++; $display("FAIL rstmid_valid: got %b required 0", o_valid); end
    if (o_instruction !== 16'h0000) begin errors++; $display("FAIL rstmid_instr: got %h required 0000", o_instruction); end
    if (o_imem_req !== 1'b0)        begin errors++; $display("FAIL rstmid_req: got %b required 0", o_imem_req); end
    if (o_pc !== 8'h00)             begin errors++; $display("FAIL rstmid_pc: got %h required 00", o_pc); end
    if (o_imem_addr !== 8'h00)      begin errors++; $display("FAIL rstmid_addr: got %h required 00", o_imem_addr); end
    next();
    i_rst = 1'b0; i_stall = 1'b0; i_run = 1'b0;
  endtask

  task automatic test_random();
    rand_lat = 1'b1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      i_stall = ($urandom_range(0, 9) < 3);
      i_run = ($urandom_range(0, 9) < 9);
      i_pc_load = ($urandom_range(0, 99) < 3);
      i_pc_value = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      next();
    end
    i_pc_load = 1'b0; i_stall = 1'b0; i_run = 1'b0;
    repeat (8) next();
    rand_lat = 1'b0;
  endtask

  initial begin : main
    i_rst = 1'b1; i_run = 1'b0; i_pc_load = 1'b0; i_pc_value = 8'h00; i_stall = 1'b0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_latency();
    test_pc_load();
    test_wrap_and_coincident_load();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
